inst_mem_loader: RTL and testbench

Writer-side companion to the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian byte pairs into 16-bit instruction words. Each word is written through a single-cycle write port into consecutive instruction-memory addresses, starting from a programmable base. While loading, it asserts `busy` so the CPU can be held off. It keeps a running 16-bit checksum of the words written.

---
 rtl/inst_mem_loader.sv | 161 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: takes a byte stream over valid/ready, packs big-endian byte
// pairs into 16-bit words and writes them to consecutive instruction-memory
// addresses from a programmable base. It keeps a 16-bit running checksum.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, base_address,       load request (taken in IDLE only), first word
//   word_count                 address and number of words (0..2^ADDR_WIDTH)
//   abort                      cancel an active load (HIGH/LOW/WRITE)
//   in_valid, in_data,         byte stream handshake
//   in_ready
//   wr_en, wr_address, wr_data single-cycle instruction-memory write port
//   busy, done, checksum       status: not idle, completion pulse, word sum
module inst_mem_loader #(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_address,
   output logic [15:0]           wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           checksum
);

   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HIGH  = 3'd1,
      S_LOW   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]        rem_q, rem_d;
   logic [7:0]              hi_q, hi_d;
   logic                    in_ready_q, in_ready_d;
   logic                    wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0]   wr_address_q, wr_address_d;
   logic [15:0]             wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [15:0]             checksum_q, checksum_d;
   logic                    hs;

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         hi_q         <= '0;
         in_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_address_q <= '0;
         wr_data_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         checksum_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         hi_q         <= hi_d;
         in_ready_q   <= in_ready_d;
         wr_en_q      <= wr_en_d;
         wr_address_q <= wr_address_d;
         wr_data_q    <= wr_data_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         checksum_q   <= checksum_d;
      end
   end

   // Next-state logic; outputs are precomputed from the next state so they
   // line up with the state they describe.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      hi_d         = hi_q;
      wr_address_d = wr_address_q;
      wr_data_d    = wr_data_q;
      checksum_d   = checksum_q;
      // in_ready_q mirrors "state is HIGH or LOW", so this is state-only
      hs           = in_valid && in_ready_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d     = base_address;
               rem_d      = word_count;
               checksum_d = '0;
               state_d    = (word_count == '0) ? S_DONE : S_HIGH;
            end
         end
         S_HIGH: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (hs) begin
               hi_d    = in_data;
               state_d = S_LOW;
            end
         end
         S_LOW: begin
            // Abort drops the half-assembled word
            if (abort) begin
               state_d = S_IDLE;
            end else if (hs) begin
               wr_data_d    = {hi_q, in_data};
               wr_address_d = addr_q;
               state_d      = S_WRITE;
            end
         end
         S_WRITE: begin
            // The write is already on the port; it completes even on abort
            checksum_d = checksum_q + wr_data_q;
            addr_d     = addr_q + ADDR_WIDTH'(1);
            rem_d      = rem_q - CNT_W'(1);
            if (abort) begin
               state_d = S_IDLE;
            end else if (rem_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_HIGH;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      in_ready_d = (state_d == S_HIGH) || (state_d == S_LOW);
      wr_en_d    = (state_d == S_WRITE);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
   end

   assign in_ready   = in_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_address = wr_address_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader. Inputs are driven 1 time unit after
// the rising edge; outputs are checked at that point or logged on the falling
// edge.
module tb_inst_mem_loader;

   localparam int unsigned AW = 10;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_address;
   logic [AW:0]   word_count;
   logic          abort;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_address;
   logic [15:0]   wr_data;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [AW-1:0] log_addr[$];
   logic [15:0]   log_data[$];
   int            log_cyc[$];
   int            done_cyc[$];
   bit            ready_seen;
   logic [7:0]    bytes[8];

   inst_mem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address),
      .word_count(word_count), .abort(abort), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
      .wr_address(wr_address), .wr_data(wr_data), .busy(busy), .done(done),
      .checksum(checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log writes, done pulses and ready activity mid-cycle
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_address);
         log_data.push_back(wr_data);
         log_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cyc.push_back(cyc);
      if (in_ready === 1'b1) ready_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      log_addr.delete();
      log_data.delete();
      log_cyc.delete();
      done_cyc.delete();
      ready_seen = 1'b0;
   endtask

   // Drive a start pulse; returns one cycle later with t0 = start cycle
   task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt,
                           output int t0);
      t0           = cyc;
      base_address = base;
      word_count   = cnt;
      start        = 1'b1;
      tick();
      start        = 1'b0;
   endtask

   // Feed n bytes from 'bytes'; with gap set, valid is low for two ready
   // cycles before each byte and high (junk data) while not ready.
   task automatic feed(input int n, input bit gap);
      int  idx = 0;
      int  wcnt = 0;
      int  budget = 0;
      bit  hs;
      while (idx < n && budget < 200) begin
         if (in_ready) begin
            if (gap && wcnt < 2) begin
               in_valid = 1'b0;
               wcnt++;
            end else begin
               in_valid = 1'b1;
               in_data  = bytes[idx];
            end
         end else begin
            in_valid = gap;
            in_data  = 8'hAA;
         end
         hs = in_valid && in_ready;
         tick();
         budget++;
         if (hs) begin
            idx++;
            wcnt = 0;
         end
      end
      in_valid = 1'b0;
      total++;
      if (idx != n) begin
         bad++;
         $display("FAIL feed_timeout: bytes taken %0d, required %0d", idx, n);
      end
   endtask

   // Bounded wait until done is high; returns in the done cycle
   task automatic wait_done(input string name);
      int budget = 0;
      while (done !== 1'b1 && budget < 50) begin
         tick();
         budget++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL %s_done_timeout: done=%b required 1", name, done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      in_data = '0; base_address = '0; word_count = '0;
      repeat (2) tick();
      total++;
      if ({in_ready, wr_en, busy, done} !== 4'b0 || wr_address !== '0 ||
          wr_data !== '0 || checksum !== '0) begin
         bad++;
         $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b addr=%h data=%h sum=%h required all 0",
                  in_ready, wr_en, busy, done, wr_address, wr_data, checksum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int t0;
      clear_logs();
      bytes[0] = 8'hE1; bytes[1] = 8'h00; bytes[2] = 8'h07; bytes[3] = 8'hF4;
      do_start(10'd0, 11'd2, t0);
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_busy_rise: busy=%b rdy=%b required 1 1", busy, in_ready);
      end
      feed(4, 1'b0);
      wait_done("basic");
      total++;
      if (cyc != t0 + 7) begin
         bad++;
         $display("FAIL basic_done_cycle: got %0d required %0d", cyc - t0, 7);
      end
      // start during DONE must be ignored
      base_address = 10'd50; word_count = 11'd1; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL basic_busy_fall: busy=%b done=%b required 0 0", busy, done);
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL start_in_done_ignored: busy=%b required 0", busy);
      end
      total++;
      if (log_addr.size() != 2) begin
         bad++;
         $display("FAIL basic_write_count: got %0d required 2", log_addr.size());
      end else if (log_addr[0] !== 10'd0 || log_data[0] !== 16'hE100 || log_cyc[0] != t0 + 3 ||
                   log_addr[1] !== 10'd1 || log_data[1] !== 16'h07F4 || log_cyc[1] != t0 + 6) begin
         bad++;
         $display("FAIL basic_writes: %h@%0d c%0d, %h@%0d c%0d required e100@0 c3, 07f4@1 c6",
                  log_data[0], log_addr[0], log_cyc[0] - t0, log_data[1], log_addr[1], log_cyc[1] - t0);
      end
      repeat (3) tick();
      total++;
      if (checksum !== 16'hE8F4) begin
         bad++;
         $display("FAIL basic_checksum_hold: got %h required e8f4", checksum);
      end
   endtask

   task automatic test_wrap();
      int t0;
      clear_logs();
      bytes[0] = 8'h00; bytes[1] = 8'h01; bytes[2] = 8'h00; bytes[3] = 8'h02;
      do_start(10'd1023, 11'd2, t0);
      feed(4, 1'b0);
      wait_done("wrap");
      tick();
      total++;
      if (log_addr.size() != 2) begin
         bad++;
         $display("FAIL wrap_write_count: got %0d required 2", log_addr.size());
      end else if (log_addr[0] !== 10'd1023 || log_addr[1] !== 10'd0 ||
                   log_data[0] !== 16'h0001 || log_data[1] !== 16'h0002) begin
         bad++;
         $display("FAIL wrap_writes: %h@%0d %h@%0d required 0001@1023 0002@0",
                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
      end
      total++;
      if (checksum !== 16'h0003) begin
         bad++;
         $display("FAIL wrap_checksum: got %h required 0003", checksum);
      end
   endtask

   task automatic test_zero_count();
      int t0;
      clear_logs();
      do_start(10'd7, 11'd0, t0);
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || checksum !== 16'h0000) begin
         bad++;
         $display("FAIL zero_done_pulse: done=%b busy=%b sum=%h required 1 1 0000", done, busy, checksum);
      end
      repeat (3) tick();
      total++;
      if (busy !== 1'b0 || log_addr.size() != 0 || ready_seen || done_cyc.size() != 1) begin
         bad++;
         $display("FAIL zero_quiet: busy=%b writes=%0d ready_seen=%b dones=%0d required 0 0 0 1",
                  busy, log_addr.size(), ready_seen, done_cyc.size());
      end
   endtask

   task automatic test_stall_gaps();
      int t0;
      clear_logs();
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
      do_start(10'd100, 11'd2, t0);
      feed(4, 1'b1);
      wait_done("stall");
      tick();
      total++;
      if (log_addr.size() != 2) begin
         bad++;
         $display("FAIL stall_write_count: got %0d required 2", log_addr.size());
      end else if (log_addr[0] !== 10'd100 || log_data[0] !== 16'h1234 ||
                   log_addr[1] !== 10'd101 || log_data[1] !== 16'h5678) begin
         bad++;
         $display("FAIL stall_writes: %h@%0d %h@%0d required 1234@100 5678@101",
                  log_data[0], log_addr[0], log_data[1], log_addr[1]);
      end
      total++;
      if (checksum !== 16'h68AC || done_cyc.size() != 1) begin
         bad++;
         $display("FAIL stall_checksum: sum=%h dones=%0d required 68ac 1", checksum, done_cyc.size());
      end
   endtask

   task automatic test_abort();
      int t0;
      clear_logs();
      do_start(10'd10, 11'd3, t0);
      in_valid = 1'b1; in_data = 8'h11; tick();
      in_data = 8'h22; tick();
      total++;
      if (wr_en !== 1'b1 || wr_address !== 10'd10 || wr_data !== 16'h1122 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL abort_word1: we=%b addr=%0d data=%h rdy=%b required 1 10 1122 0",
                  wr_en, wr_address, wr_data, in_ready);
      end
      tick();
      in_data = 8'h33; tick();
      in_data = 8'h44; abort = 1'b1; tick();
      abort = 1'b0; in_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle: busy=%b rdy=%b we=%b done=%b required 0 0 0 0",
                  busy, in_ready, wr_en, done);
      end
      repeat (4) tick();
      total++;
      if (log_addr.size() != 1 || done_cyc.size() != 0 || checksum !== 16'h1122) begin
         bad++;
         $display("FAIL abort_effects: writes=%0d dones=%0d sum=%h required 1 0 1122",
                  log_addr.size(), done_cyc.size(), checksum);
      end
      clear_logs();
      bytes[0] = 8'hBE; bytes[1] = 8'hEF;
      do_start(10'd20, 11'd1, t0);
      feed(2, 1'b0);
      wait_done("abort_restart");
      tick();
      total++;
      if (log_addr.size() != 1 || log_addr[0] !== 10'd20 || log_data[0] !== 16'hBEEF ||
          checksum !== 16'hBEEF) begin
         bad++;
         $display("FAIL abort_restart: writes=%0d sum=%h required 1 write beef@20 sum beef",
                  log_addr.size(), checksum);
      end
   endtask

   task automatic test_reset_mid_write();
      int t0;
      clear_logs();
      do_start(10'd5, 11'd2, t0);
      in_valid = 1'b1; in_data = 8'hAB; tick();
      in_data = 8'hCD; tick();
      in_valid = 1'b0;
      total++;
      if (wr_en !== 1'b1 || wr_data !== 16'hABCD) begin
         bad++;
         $display("FAIL rst_pre_write: we=%b data=%h required 1 abcd", wr_en, wr_data);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({in_ready, wr_en, busy, done} !== 4'b0 || wr_address !== '0 ||
          wr_data !== '0 || checksum !== '0) begin
         bad++;
         $display("FAIL rst_async_clear: rdy=%b we=%b busy=%b done=%b addr=%h data=%h sum=%h required all 0",
                  in_ready, wr_en, busy, done, wr_address, wr_data, checksum);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      total++;
      if (log_addr.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL rst_no_write: writes=%0d dones=%0d busy=%b required 0 0 0",
                  log_addr.size(), done_cyc.size(), busy);
      end
      bytes[0] = 8'h0F; bytes[1] = 8'hF0;
      do_start(10'd3, 11'd1, t0);
      feed(2, 1'b0);
      wait_done("rst_restart");
      tick();
      total++;
      if (log_addr.size() != 1 || log_addr[0] !== 10'd3 || log_data[0] !== 16'h0FF0) begin
         bad++;
         $display("FAIL rst_restart: writes=%0d required 1 write 0ff0@3", log_addr.size());
      end
   endtask

   task automatic test_checksum_wrap();
      int t0;
      clear_logs();
      bytes[0] = 8'hFF; bytes[1] = 8'hFF; bytes[2] = 8'h00; bytes[3] = 8'h02;
      do_start(10'd200, 11'd2, t0);
      feed(4, 1'b0);
      wait_done("sumwrap");
      tick();
      total++;
      if (checksum !== 16'h0001) begin
         bad++;
         $display("FAIL checksum_wrap: got %h required 0001", checksum);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_zero_count();
      test_stall_gaps();
      test_abort();
      test_reset_mid_write();
      test_checksum_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
